// File: rtl/dili_pkg.sv
`default_nettype none
// =============================================================================
// Module   : dili_pkg
// Purpose  : Shared Dilithium stream types and field-width constants.
// Revision : 1.0
// =============================================================================
package dili_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dili_state_e;

    localparam int DILI_MAXW = 20;
    localparam int DILI_N    = 256;

    localparam int W_T1  = 10;
    localparam int W_T0  = 13;
    localparam int W_Z   = 20;
    localparam int W_ETA = 3;
    localparam int W_W1  = 6;

endpackage
`default_nettype wire

// File: rtl/dili_bit_unpacker.sv
`default_nettype none
// =============================================================================
// Module   : dili_bit_unpacker
// Purpose  : Slices a byte stream LSB-first into fixed-width fields for the
//            HWDILI coefficient decoder. Macro UNPACK_BYTECNT_EN adds byte_cnt.
// Revision : 1.0
// =============================================================================
module dili_bit_unpacker
    import dili_pkg::*;
#(
    parameter int pMAXW = DILI_MAXW,
    parameter int pBUFW = 32,
    parameter int pCNTW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       cfg_width,
    input  logic [pCNTW-1:0] cfg_count,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [pMAXW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef UNPACK_BYTECNT_EN
    output logic [15:0]      byte_cnt,
`endif
    output logic             out_last
);

    localparam int BCW = $clog2(pBUFW + 1);
    localparam int RBW = pCNTW + 5;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;
    localparam logic [4:0] MAXW5   = 5'(pMAXW);

    logic [1:0]       state;
    logic [pBUFW-1:0] bit_buf;
    logic [BCW-1:0]   bitcnt;
    logic [4:0]       width_q;
    logic [pCNTW-1:0] count_q;
    logic [pCNTW-1:0] load_cnt;
    logic [RBW-1:0]   rem_bits;

    logic             cfg_legal;
    logic             accept;
    logic             fire;
    logic             load;
    logic [pMAXW-1:0] field_mask;
    logic [pBUFW-1:0] buf_shift;
    logic [pBUFW-1:0] buf_next;
    logic [BCW-1:0]   cnt_shift;
    logic [BCW-1:0]   cnt_next;

    assign cfg_legal  = (cfg_width != 5'd0) && (cfg_width <= MAXW5) && (cfg_count != '0);
    // rem_bits gates intake so no byte beyond the last field is ever taken
    assign in_ready   = (state == ST_RUN) && (bitcnt <= BCW'(pBUFW - 8)) && (rem_bits != '0);
    assign accept     = in_valid && in_ready;
    assign fire       = out_valid && out_ready;
    assign load       = (state == ST_RUN) && (bitcnt >= BCW'(width_q)) &&
                        (load_cnt != count_q) && (!out_valid || out_ready);
    assign field_mask = ~({pMAXW{1'b1}} << width_q);
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

    always_comb begin
        buf_shift = load ? (bit_buf >> width_q) : bit_buf;
        cnt_shift = load ? (bitcnt - BCW'(width_q)) : bitcnt;
        buf_next  = buf_shift;
        cnt_next  = cnt_shift;
        if (accept) begin
            buf_next = buf_shift | (pBUFW'(in_data) << cnt_shift);
            cnt_next = cnt_shift + BCW'(8);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_buf   <= '0;
            bitcnt    <= '0;
            width_q   <= '0;
            count_q   <= '0;
            load_cnt  <= '0;
            rem_bits  <= '0;
            err_cfg   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            state    <= ST_RUN;
                            width_q  <= cfg_width;
                            count_q  <= cfg_count;
                            load_cnt <= '0;
                            bit_buf  <= '0;
                            bitcnt   <= '0;
                            rem_bits <= RBW'(cfg_width) * RBW'(cfg_count);
                            err_cfg  <= 1'b0;
                        end else begin
                            err_cfg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    bit_buf <= buf_next;
                    bitcnt  <= cnt_next;
                    if (accept) begin
                        rem_bits <= (rem_bits > RBW'(8)) ? (rem_bits - RBW'(8)) : '0;
                    end
                    if (load) begin
                        out_data  <= bit_buf[pMAXW-1:0] & field_mask;
                        out_valid <= 1'b1;
                        out_last  <= (load_cnt == (count_q - pCNTW'(1)));
                        load_cnt  <= load_cnt + pCNTW'(1);
                    end else if (fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // padding bits left after the final field are dropped here
                    if (fire && out_last) begin
                        state   <= ST_DONE;
                        bit_buf <= '0;
                        bitcnt  <= '0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UNPACK_BYTECNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if ((state == ST_IDLE) && start && cfg_legal) begin
            byte_cnt <= '0;
        end else if (accept && (byte_cnt != 16'hFFFF)) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
